counter_service_seq: RTL and testbench

Responder side of the counter-request interface: services the plus/minus increment requests raised by the counter-cell logic for the CDU/PIPA/shaft/trunnion counters. The block arbitrates pending requests by fixed priority, addresses one counter per service slot, commands a PINC/MINC through the arithmetic unit, and, on completion, returns the per-counter request-reset pulse that clears the requesting cell. It sits between the counter cells and the sequence generator / central ALU.

---
 rtl/counter_service_seq.sv | 146 ++++++++++++++
 tb/tb_counter_service_seq.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_service_seq.sv
// Fixed-priority responder for counter-cell PINC/MINC requests: select, command, await DONE, reset cell.
// Optional macro CTR_CASCADE_EN: counter overflow raises a carry request on the next counter.
module counter_service_seq #(
    parameter int NCTR      = 10,
    parameter int STALL_MAX = 15
) (
    input  logic            CLOCK,
    input  logic            rst,
    input  logic            SLOT,
    input  logic [NCTR-1:0] CNTP,
    input  logic [NCTR-1:0] CNTM,
    input  logic            DONE,
    input  logic            OVF,
    output logic [NCTR-1:0] CSEL,
    output logic            PINC,
    output logic            MINC,
    output logic [NCTR-1:0] CRST,
    output logic            BUSY,
    output logic            ERR,
    output logic [1:0]      state_dbg
);
    localparam int IW = (NCTR > 1) ? $clog2(NCTR) : 1;
    localparam int CW = $clog2(STALL_MAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_WAIT, S_RST} state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   idx_q, idx_nxt, pend_idx;
    logic            plus_q, minus_q, plus_nxt, minus_nxt;
    logic [CW-1:0]   wait_cnt, cnt_nxt;
    logic [NCTR-1:0] carry_p, carry_m, req_p, req_m, onehot;
    logic            pend_found, timeout, csel_on;

    assign req_p     = CNTP | carry_p;
    assign req_m     = CNTM | carry_m;
    assign state_dbg = state;

    // SLOT and DONE are single-cycle pulses with no back-pressure: a SLOT seen outside
    // IDLE is simply lost, and DONE only counts while the command is outstanding (WAIT).
    always_comb begin
        pend_found = 1'b0;
        pend_idx   = '0;
        for (int i = NCTR - 1; i >= 0; i--) begin
            if (req_p[i] | req_m[i]) begin
                pend_found = 1'b1;
                pend_idx   = IW'(i);
            end
        end
    end

    always_comb begin
        onehot        = '0;
        onehot[idx_q] = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx_q;
        plus_nxt  = plus_q;
        minus_nxt = minus_q;
        cnt_nxt   = wait_cnt;
        timeout   = 1'b0;
        case (state)
            S_IDLE: begin
                if (SLOT && pend_found) begin
                    state_nxt = S_CMD;
                    idx_nxt   = pend_idx;
                    plus_nxt  = req_p[pend_idx];
                    minus_nxt = req_m[pend_idx];
                end
            end
            S_CMD: begin
                cnt_nxt   = '0;
                state_nxt = (plus_q & minus_q) ? S_RST : S_WAIT;
            end
            S_WAIT: begin
                if (DONE) begin
                    state_nxt = S_RST;
                end else if (wait_cnt == CW'(STALL_MAX - 1)) begin
                    timeout   = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = wait_cnt + CW'(1);
                end
            end
            S_RST:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        csel_on = (state == S_CMD) | ((state == S_WAIT) & ~timeout);
    end

    // Outputs are decoded from the current state and registered, so they trail the state by one edge.
    always_ff @(posedge CLOCK or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            idx_q    <= '0;
            plus_q   <= 1'b0;
            minus_q  <= 1'b0;
            wait_cnt <= '0;
            CSEL     <= '0;
            PINC     <= 1'b0;
            MINC     <= 1'b0;
            CRST     <= '0;
            BUSY     <= 1'b0;
            ERR      <= 1'b0;
        end else begin
            state    <= state_nxt;
            idx_q    <= idx_nxt;
            plus_q   <= plus_nxt;
            minus_q  <= minus_nxt;
            wait_cnt <= cnt_nxt;
            CSEL     <= csel_on ? onehot : '0;
            PINC     <= csel_on & plus_q & ~minus_q;
            MINC     <= csel_on & minus_q & ~plus_q;
            CRST     <= (state == S_RST) ? onehot : '0;
            BUSY     <= (state != S_IDLE) & ~timeout;
            ERR      <= timeout;
        end
    end

`ifdef CTR_CASCADE_EN
    logic cascade;
    assign cascade = (state == S_WAIT) & DONE & OVF & (idx_q != IW'(NCTR - 1));

    always_ff @(posedge CLOCK or negedge rst) begin
        if (!rst) begin
            carry_p <= '0;
            carry_m <= '0;
        end else begin
            if (state == S_RST) begin
                carry_p[idx_q] <= 1'b0;
                carry_m[idx_q] <= 1'b0;
            end
            // A carry into an already-pending counter merges with it; overflow is not counted.
            if (cascade && plus_q) carry_p[idx_q + IW'(1)] <= 1'b1;
            if (cascade && minus_q) carry_m[idx_q + IW'(1)] <= 1'b1;
        end
    end
`else
    logic unused_ovf;
    assign carry_p    = '0;
    assign carry_m    = '0;
    assign unused_ovf = OVF;
`endif

endmodule

// File: tb/tb_counter_service_seq.sv
// Scenario bench for counter_service_seq: expected service commands are queued at stimulus time.
module tb_counter_service_seq;
    localparam int NCTR      = 10;
    localparam int STALL_MAX = 15;
    localparam int W         = NCTR + 2;

    logic            CLOCK, rst, SLOT, DONE, OVF;
    logic [NCTR-1:0] CNTP, CNTM, CSEL, CRST;
    logic            PINC, MINC, BUSY, ERR;
    logic [1:0]      state_dbg;

    logic [W-1:0] exp_q[$];
    int vec_cnt = 0;
    int err_cnt = 0;

    counter_service_seq #(.NCTR(NCTR), .STALL_MAX(STALL_MAX)) dut (
        .CLOCK(CLOCK), .rst(rst), .SLOT(SLOT), .CNTP(CNTP), .CNTM(CNTM),
        .DONE(DONE), .OVF(OVF), .CSEL(CSEL), .PINC(PINC), .MINC(MINC),
        .CRST(CRST), .BUSY(BUSY), .ERR(ERR), .state_dbg(state_dbg)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge CLOCK);
    endtask

    task automatic pulse_slot();
        tick();
        SLOT = 1'b1;
        tick();
        SLOT = 1'b0;
    endtask

    // Called while the DUT is in WAIT; returns CRST one cycle after DONE and BUSY two cycles after.
    task automatic complete(input logic ovf, output logic [NCTR-1:0] crst_obs, output logic busy_obs);
        DONE = 1'b1;
        OVF  = ovf;
        tick();
        DONE = 1'b0;
        OVF  = 1'b0;
        tick();
        crst_obs = CRST;
        tick();
        busy_obs = BUSY;
    endtask

    function automatic logic [W-1:0] svc(input int k, input logic p, input logic m);
        logic [NCTR-1:0] oh;
        oh    = '0;
        oh[k] = 1'b1;
        return {oh, p, m};
    endfunction

    task automatic test_reset();
        logic [W-1:0] got, exp;
        logic [NCTR-1:0] crst;
        logic busy;
        rst = 1'b0;
        repeat (3) tick();
        vec_cnt++;
        if ({CSEL, PINC, MINC, CRST, BUSY, ERR, state_dbg} !== '0) begin
            err_cnt++;
            $display("FAIL reset_state: got %h required 0", {CSEL, PINC, MINC, CRST, BUSY, ERR, state_dbg});
        end
        rst = 1'b1;
        tick();
        CNTP[3] = 1'b1;
        exp_q.push_back(svc(3, 1'b1, 1'b0));
        pulse_slot();
        tick();
        got = {CSEL, PINC, MINC};
        exp = exp_q.pop_front();
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL reset_first_cmd: got %h required %h", got, exp);
        end
        tick();
        tick();
        #2 rst = 1'b0;
        #1;
        vec_cnt++;
        if ({CSEL, PINC, MINC, CRST, BUSY, ERR} !== '0) begin
            err_cnt++;
            $display("FAIL reset_async: got %h required 0", {CSEL, PINC, MINC, CRST, BUSY, ERR});
        end
        tick();
        rst = 1'b1;
        tick();
        exp_q.push_back(svc(3, 1'b1, 1'b0));
        pulse_slot();
        tick();
        got = {CSEL, PINC, MINC};
        exp = exp_q.pop_front();
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL reset_retry_cmd: got %h required %h", got, exp);
        end
        complete(1'b0, crst, busy);
        vec_cnt++;
        if (crst !== 10'h008 || busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_retry_crst: got crst=%h busy=%b required crst=008 busy=0", crst, busy);
        end
        CNTP[3] = 1'b0;
    endtask

    task automatic test_priority();
        logic [W-1:0] got, exp;
        logic [NCTR-1:0] crst;
        logic busy;
        CNTP[2] = 1'b1;
        CNTM[5] = 1'b1;
        exp_q.push_back(svc(2, 1'b1, 1'b0));
        pulse_slot();
        vec_cnt++;
        if ({CSEL, BUSY} !== '0) begin
            err_cnt++;
            $display("FAIL prio_latency: got csel=%h busy=%b required 0 one edge after SLOT", CSEL, BUSY);
        end
        tick();
        got = {CSEL, PINC, MINC};
        exp = exp_q.pop_front();
        vec_cnt++;
        if (got !== exp || BUSY !== 1'b1) begin
            err_cnt++;
            $display("FAIL prio_first_cmd: got %h busy=%b required %h busy=1", got, BUSY, exp);
        end
        complete(1'b0, crst, busy);
        vec_cnt++;
        if (crst !== 10'h004 || busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL prio_first_crst: got crst=%h busy=%b required crst=004 busy=0", crst, busy);
        end
        CNTP[2] = 1'b0;
        exp_q.push_back(svc(5, 1'b0, 1'b1));
        pulse_slot();
        tick();
        got = {CSEL, PINC, MINC};
        exp = exp_q.pop_front();
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL prio_second_cmd: got %h required %h", got, exp);
        end
        complete(1'b0, crst, busy);
        vec_cnt++;
        if (crst !== 10'h020 || busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL prio_second_crst: got crst=%h busy=%b required crst=020 busy=0", crst, busy);
        end
        CNTM[5] = 1'b0;
    endtask

    task automatic test_cancel();
        logic [W-1:0] got, exp;
        CNTP[0] = 1'b1;
        CNTM[0] = 1'b1;
        exp_q.push_back(svc(0, 1'b0, 1'b0));
        pulse_slot();
        tick();
        got = {CSEL, PINC, MINC};
        exp = exp_q.pop_front();
        vec_cnt++;
        if (got !== exp || BUSY !== 1'b1) begin
            err_cnt++;
            $display("FAIL cancel_cmd: got %h busy=%b required %h busy=1", got, BUSY, exp);
        end
        tick();
        vec_cnt++;
        if (CRST !== 10'h001 || PINC !== 1'b0 || MINC !== 1'b0) begin
            err_cnt++;
            $display("FAIL cancel_crst: got crst=%h p=%b m=%b required crst=001 p=0 m=0", CRST, PINC, MINC);
        end
        tick();
        vec_cnt++;
        if (BUSY !== 1'b0 || CRST !== '0) begin
            err_cnt++;
            $display("FAIL cancel_idle: got busy=%b crst=%h required busy=0 crst=000", BUSY, CRST);
        end
        CNTP[0] = 1'b0;
        CNTM[0] = 1'b0;
    endtask

    task automatic test_timeout();
        logic [W-1:0] got, exp;
        logic [NCTR-1:0] crst, crst_any;
        logic busy;
        int cnt;
        CNTM[1] = 1'b1;
        exp_q.push_back(svc(1, 1'b0, 1'b1));
        pulse_slot();
        tick();
        cnt = 1;
        crst_any = CRST;
        got = {CSEL, PINC, MINC};
        exp = exp_q.pop_front();
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL timeout_cmd: got %h required %h", got, exp);
        end
        while (cnt < 40 && ERR !== 1'b1) begin
            tick();
            cnt++;
            crst_any |= CRST;
        end
        vec_cnt++;
        if (cnt != STALL_MAX + 1) begin
            err_cnt++;
            $display("FAIL timeout_latency: got ERR after %0d cycles required %0d", cnt, STALL_MAX + 1);
        end
        vec_cnt++;
        if ({CSEL, PINC, MINC, BUSY} !== '0 || crst_any !== '0) begin
            err_cnt++;
            $display("FAIL timeout_drop: got csel=%h p=%b m=%b busy=%b crst_any=%h required all 0",
                     CSEL, PINC, MINC, BUSY, crst_any);
        end
        tick();
        vec_cnt++;
        if (ERR !== 1'b0) begin
            err_cnt++;
            $display("FAIL timeout_pulse: got err=%b required 0", ERR);
        end
        exp_q.push_back(svc(1, 1'b0, 1'b1));
        pulse_slot();
        tick();
        got = {CSEL, PINC, MINC};
        exp = exp_q.pop_front();
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL timeout_retry_cmd: got %h required %h", got, exp);
        end
        complete(1'b0, crst, busy);
        vec_cnt++;
        if (crst !== 10'h002 || busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL timeout_retry_crst: got crst=%h busy=%b required crst=002 busy=0", crst, busy);
        end
        CNTM[1] = 1'b0;
    endtask

    task automatic test_cascade();
        logic [W-1:0] got, exp;
        logic [NCTR-1:0] crst;
        logic busy;
        CNTP[4] = 1'b1;
        exp_q.push_back(svc(4, 1'b1, 1'b0));
        pulse_slot();
        tick();
        got = {CSEL, PINC, MINC};
        exp = exp_q.pop_front();
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL cascade_src_cmd: got %h required %h", got, exp);
        end
        complete(1'b1, crst, busy);
        vec_cnt++;
        if (crst !== 10'h010) begin
            err_cnt++;
            $display("FAIL cascade_src_crst: got %h required 010", crst);
        end
        CNTP[4] = 1'b0;
`ifdef CTR_CASCADE_EN
        exp_q.push_back(svc(5, 1'b1, 1'b0));
        pulse_slot();
        tick();
        got = {CSEL, PINC, MINC};
        exp = exp_q.pop_front();
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL cascade_carry_cmd: got %h required %h", got, exp);
        end
        complete(1'b0, crst, busy);
        vec_cnt++;
        if (crst !== 10'h020) begin
            err_cnt++;
            $display("FAIL cascade_carry_crst: got %h required 020", crst);
        end
`endif
        pulse_slot();
        tick();
        vec_cnt++;
        if ({CSEL, BUSY} !== '0) begin
            err_cnt++;
            $display("FAIL cascade_idle: got csel=%h busy=%b required 0", CSEL, BUSY);
        end
        CNTP[9] = 1'b1;
        exp_q.push_back(svc(9, 1'b1, 1'b0));
        pulse_slot();
        tick();
        got = {CSEL, PINC, MINC};
        exp = exp_q.pop_front();
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL cascade_top_cmd: got %h required %h", got, exp);
        end
        complete(1'b1, crst, busy);
        CNTP[9] = 1'b0;
        pulse_slot();
        tick();
        vec_cnt++;
        if ({CSEL, BUSY} !== '0 || crst !== 10'h200) begin
            err_cnt++;
            $display("FAIL cascade_top_discard: got csel=%h busy=%b crst=%h required 0 0 200", CSEL, BUSY, crst);
        end
    endtask

    task automatic test_dropped_slot();
        logic [W-1:0] got, exp;
        logic [NCTR-1:0] crst, csel_any;
        logic busy, busy_any;
        CNTP[6] = 1'b1;
        CNTM[8] = 1'b1;
        exp_q.push_back(svc(6, 1'b1, 1'b0));
        pulse_slot();
        tick();
        got = {CSEL, PINC, MINC};
        exp = exp_q.pop_front();
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL drop_cmd: got %h required %h", got, exp);
        end
        pulse_slot();
        complete(1'b0, crst, busy);
        CNTP[6] = 1'b0;
        csel_any = '0;
        busy_any = busy;
        repeat (6) begin
            tick();
            csel_any |= CSEL;
            busy_any |= BUSY;
        end
        vec_cnt++;
        if (crst !== 10'h040 || csel_any !== '0 || busy_any !== 1'b0) begin
            err_cnt++;
            $display("FAIL drop_single: got crst=%h csel_any=%h busy_any=%b required 040 000 0",
                     crst, csel_any, busy_any);
        end
        CNTM[8] = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] got, exp;
        logic [NCTR-1:0] pm, mm, crst, exp_oh;
        logic busy;
        int k;
        repeat (2) begin
            pm = NCTR'($urandom_range(1, (1 << NCTR) - 1));
            mm = NCTR'($urandom_range(0, (1 << NCTR) - 1)) & ~pm;
            CNTP = pm;
            CNTM = mm;
            for (int it = 0; it < 2 * NCTR && (pm | mm) != '0; it++) begin
                k = 0;
                for (int i = NCTR - 1; i >= 0; i--) if (pm[i] | mm[i]) k = i;
                exp_q.push_back(svc(k, pm[k], mm[k]));
                exp_oh = '0;
                exp_oh[k] = 1'b1;
                pulse_slot();
                tick();
                got = {CSEL, PINC, MINC};
                exp = exp_q.pop_front();
                vec_cnt++;
                if (got !== exp) begin
                    err_cnt++;
                    $display("FAIL b2b_cmd: got %h required %h", got, exp);
                end
                complete(1'b0, crst, busy);
                vec_cnt++;
                if (crst !== exp_oh || busy !== 1'b0) begin
                    err_cnt++;
                    $display("FAIL b2b_crst: got crst=%h busy=%b required crst=%h busy=0", crst, busy, exp_oh);
                end
                pm[k] = 1'b0;
                mm[k] = 1'b0;
                CNTP = pm;
                CNTM = mm;
            end
        end
    endtask

    initial begin
        rst  = 1'b0;
        SLOT = 1'b0;
        DONE = 1'b0;
        OVF  = 1'b0;
        CNTP = '0;
        CNTM = '0;
        test_reset();
        test_priority();
        test_cancel();
        test_timeout();
        test_cascade();
        test_dropped_slot();
        test_back_to_back();
        vec_cnt++;
        if (exp_q.size() != 0) begin
            err_cnt++;
            $display("FAIL scoreboard_drain: got %0d entries left required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
